// File: rtl/mem_arbiter.sv
// Arbitrates one fixed-latency, single-ported unified memory between instruction
// fetch and data access. Grants one access at a time and stalls whichever requester is waiting.
module mem_arbiter #(
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_be,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic {GNT_FETCH, GNT_DATA} gnt_t;

  state_t           state, state_nxt;
  gnt_t             gnt, last_gnt;
  logic [CNT_W-1:0] cnt;
  logic             grant_c;
  logic             pick_data_c;

  // Byte offset and out-of-range upper address bits are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                              d_addr[31:ADDR_W+2], d_addr[1:0]};

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; RESP always returns to IDLE so a held request is not serviced twice
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (if_req || d_req) state_nxt = BUSY;
      BUSY:    if (cnt == '0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant decision: on a tie, serve the requester that was not served last
  always_comb begin
    grant_c     = 1'b0;
    pick_data_c = 1'b0;
    if (state == IDLE) begin
      grant_c     = if_req | d_req;
      pick_data_c = d_req & (~if_req | (last_gnt == GNT_FETCH));
    end
  end

  // Memory-side registers, read-data capture and ack pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt       <= GNT_FETCH;
      last_gnt  <= GNT_FETCH;
      cnt       <= '0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_c) begin
            cnt    <= CNT_W'(MEM_LAT - 1);
            mem_en <= 1'b1;
            if (pick_data_c) begin
              gnt       <= GNT_DATA;
              last_gnt  <= GNT_DATA;
              mem_addr  <= d_addr[ADDR_W+1:2];
              mem_we    <= d_we;
              mem_wdata <= d_wdata;
              mem_be    <= d_be;
            end else begin
              gnt       <= GNT_FETCH;
              last_gnt  <= GNT_FETCH;
              mem_addr  <= if_addr[ADDR_W+1:2];
              mem_we    <= 1'b0;
              mem_wdata <= '0;
              mem_be    <= '0;
            end
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if (gnt == GNT_DATA) begin
              d_ack <= 1'b1;
              if (!mem_we) d_rdata <= mem_rdata;
            end else begin
              if_ack   <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Stalls drop in the ack cycle so the pipeline advances on that edge
  assign stall_if  = rst & if_req & ~if_ack;
  assign stall_mem = rst & d_req & ~d_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected grants/acks into queues,
// a negedge monitor pops and compares whenever the DUT starts an access or acks.
module tb_mem_arbiter;

  localparam int unsigned AW  = 6;
  localparam int unsigned LAT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_ack, d_req, d_we, d_ack;
  logic [31:0]   if_addr, if_rdata, d_addr, d_wdata, d_rdata;
  logic [3:0]    d_be, mem_be;
  logic          stall_if, stall_mem, mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic [31:0]   mem_model [64];

  mem_arbiter #(.ADDR_W(AW), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem_model[mem_addr];

  always #5 clk = ~clk;

  typedef struct {
    bit          data;
    bit          we;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
  } txn_t;

  txn_t exp_gnt[$];
  txn_t exp_ack[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   rise_cyc = 0;
  int   ack_cnt = 0;
  logic en_q = 1'b0;
  logic ack_q = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic txn_t mk(input bit data, input bit we, input logic [5:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be,
                              input logic [31:0] rdata);
    txn_t t;
    t.data = data; t.we = we; t.addr = addr; t.wdata = wdata; t.be = be; t.rdata = rdata;
    return t;
  endfunction

  task automatic expect_txn(input txn_t t);
    exp_gnt.push_back(t);
    exp_ack.push_back(t);
  endtask

  // Waits (bounded) for the requester's ack, then returns just after the ack edge
  task automatic wait_ack(input bit data);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(data ? d_ack : if_ack) && n < 100);
    if (!(data ? d_ack : if_ack)) begin
      total++;
      bad++;
      $display("FAIL ack_timeout: no ack for requester %0d after %0d cycles", data, n);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_fetch(input logic [31:0] a);
    if_req = 1'b1; if_addr = a;
    wait_ack(1'b0);
    if_req = 1'b0;
  endtask

  task automatic do_data(input bit we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be);
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; d_be = be;
    wait_ack(1'b1);
    d_req = 1'b0; d_we = 1'b0;
  endtask

  // Monitor: checks each access start, its BUSY length and each ack
  always @(negedge clk) begin
    txn_t e;
    cyc++;
    if (!rst) begin
      en_q  = 1'b0;
      ack_q = 1'b0;
    end else begin
      if (mem_en && !en_q) begin
        rise_cyc = cyc;
        if (exp_gnt.size() == 0) begin
          check("unexpected_grant", 32'(mem_en), 32'd0);
        end else begin
          e = exp_gnt.pop_front();
          check("gnt_addr", 32'(mem_addr), 32'(e.addr));
          check("gnt_we", 32'(mem_we), 32'(e.we));
          check("gnt_be", 32'(mem_be), 32'(e.be));
          if (e.data && e.we) check("gnt_wdata", mem_wdata, e.wdata);
          check("gnt_stall", e.data ? 32'(stall_mem) : 32'(stall_if), 32'd1);
        end
      end
      if (!mem_en && en_q) check("busy_len", 32'(cyc - rise_cyc), 32'(LAT));
      if (if_ack || d_ack) begin
        ack_cnt++;
        check("ack_single_cycle", 32'(ack_q), 32'd0);
        check("ack_exclusive", 32'(if_ack & d_ack), 32'd0);
        check("ack_latency", 32'(cyc - rise_cyc), 32'(LAT));
        if (exp_ack.size() == 0) begin
          check("unexpected_ack", 32'(if_ack | d_ack), 32'd0);
        end else begin
          e = exp_ack.pop_front();
          check("ack_who", 32'(d_ack), 32'(e.data));
          check("ack_rdata", e.data ? d_rdata : if_rdata, e.rdata);
          check("ack_stall_low", e.data ? 32'(stall_mem) : 32'(stall_if), 32'd0);
        end
      end
      en_q  = mem_en;
      ack_q = if_ack | d_ack;
    end
  end

  initial begin
    int first_ack;
    int second_ack;
    int n;
    int acks_before;

    for (int i = 0; i < 64; i++) mem_model[i] = 32'h0A00_0000 | 32'(i);
    mem_model[4] = 32'hDEADBEEF;

    // Reset with random inputs: every output must read 0
    rst = 1'b0;
    if_req = 1'($urandom_range(0, 1)); if_addr = $urandom;
    d_req = 1'($urandom_range(0, 1)); d_we = 1'($urandom_range(0, 1));
    d_addr = $urandom; d_wdata = $urandom; d_be = 4'($urandom);
    @(posedge clk); #1;
    if_req = 1'b1; d_req = 1'b1;
    @(posedge clk); #1;
    check("rst_if_ack", 32'(if_ack), 32'd0);
    check("rst_d_ack", 32'(d_ack), 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_be", 32'(mem_be), 32'd0);
    check("rst_stall_if", 32'(stall_if), 32'd0);
    check("rst_stall_mem", 32'(stall_mem), 32'd0);
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_mem_en", 32'(mem_en), 32'd0);
    check("idle_no_ack", 32'(ack_cnt), 32'd0);

    // Fetch of byte 0x10 -> word 4
    @(posedge clk); #1;
    expect_txn(mk(1'b0, 1'b0, 6'd4, 32'h0, 4'b0000, 32'hDEADBEEF));
    if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk);
    check("fetch_stall_if", 32'(stall_if), 32'd1);
    wait_ack(1'b0);
    if_req = 1'b0;

    // Store to byte 0x20 -> word 8; d_rdata stays 0
    expect_txn(mk(1'b1, 1'b1, 6'd8, 32'h0000_1234, 4'b0011, 32'h0));
    do_data(1'b1, 32'h20, 32'h0000_1234, 4'b0011);

    // Contention from reset: DATA, FETCH, DATA, FETCH
    rst = 1'b0;
    @(posedge clk); #1;
    expect_txn(mk(1'b1, 1'b0, 6'd32, 32'h0, 4'hF, 32'h0A00_0020));
    expect_txn(mk(1'b0, 1'b0, 6'd16, 32'h0, 4'h0, 32'h0A00_0010));
    expect_txn(mk(1'b1, 1'b1, 6'd63, 32'hCAFE_F00D, 4'hF, 32'h0A00_0020));
    expect_txn(mk(1'b0, 1'b0, 6'd17, 32'h0, 4'h0, 32'h0A00_0011));
    if_req = 1'b1; if_addr = 32'h40;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; d_be = 4'hF;
    rst = 1'b1;
    fork
      begin
        do_data(1'b0, 32'h80, 32'h0, 4'hF);
        do_data(1'b1, 32'hFC, 32'hCAFE_F00D, 4'hF);
      end
      begin
        do_fetch(32'h40);
        do_fetch(32'h44);
      end
    join

    // Reset in the 2nd BUSY cycle abandons the access
    @(posedge clk); #1;
    exp_gnt.push_back(mk(1'b0, 1'b0, 6'd9, 32'h0, 4'h0, 32'h0));
    if_req = 1'b1; if_addr = 32'h24;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_en && n < 20);
    check("abort_busy_seen", 32'(mem_en), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("abort_mem_en_async", 32'(mem_en), 32'd0);
    check("abort_stall_if", 32'(stall_if), 32'd0);
    if_req = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    acks_before = ack_cnt;
    repeat (8) @(negedge clk);
    check("abort_no_ack", 32'(ack_cnt), 32'(acks_before));

    // Held request: two fetches, acks MEM_LAT+2 apart; upper/low address bits ignored
    @(posedge clk); #1;
    expect_txn(mk(1'b0, 1'b0, 6'd4, 32'h0, 4'h0, 32'hDEADBEEF));
    expect_txn(mk(1'b0, 1'b0, 6'd4, 32'h0, 4'h0, 32'hDEADBEEF));
    if_req = 1'b1; if_addr = 32'hFFFF_FF13;
    n = 0;
    do begin @(negedge clk); n++; end while (!if_ack && n < 50);
    first_ack = cyc;
    @(negedge clk);
    do begin @(negedge clk); n++; end while (!if_ack && n < 100);
    second_ack = cyc;
    check("held_ack_spacing", 32'(second_ack - first_ack), 32'(LAT + 2));
    @(posedge clk); #1;
    if_req = 1'b0;

    repeat (6) @(negedge clk);
    check("queues_drained", 32'(exp_gnt.size() + exp_ack.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
